// File: rtl/seat_button_conditioner_pkg.sv
// Shared constants for seat button debouncing; benches of the attendant system
// reuse the default window and the counter-width helper.
package seat_ctrl_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int DEBOUNCE_CYCLES_MIN     = 2;
  localparam int DEBOUNCE_CYCLES_MAX     = 65535;

  // The counter only has to reach DEBOUNCE_CYCLES-1, so clog2 of the window is enough.
  function automatic int debounce_cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

  localparam int DEBOUNCE_CNT_W_DEFAULT = debounce_cnt_width(DEBOUNCE_CYCLES_DEFAULT);

endpackage

// File: rtl/seat_button_conditioner_if.sv
// Raw switch inputs and conditioned levels/strobes of one passenger seat.
// master = seat/attendant side driving raw switches, slave = conditioner.
interface seat_button_conditioner_if;

  logic call_raw;
  logic cancel_raw;
  logic call_button;
  logic cancel_button;
  logic call_pulse;
  logic cancel_pulse;

  modport master (
    output call_raw,
    output cancel_raw,
    input  call_button,
    input  cancel_button,
    input  call_pulse,
    input  cancel_pulse
  );

  modport slave (
    input  call_raw,
    input  cancel_raw,
    output call_button,
    output cancel_button,
    output call_pulse,
    output cancel_pulse
  );

endinterface

// File: rtl/seat_button_conditioner_debounce.sv
// Purpose: synchronize one bouncy switch, accept a level after DEBOUNCE_CYCLES stable cycles, strobe on press.
// Latency: a level held from edge 1 shows on 'level' after edge DEBOUNCE_CYCLES+2.
// Backpressure: none; the raw input is sampled every cycle.
module debounce_channel
  import seat_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int               CNT_W    = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             differs;
  logic             accept;

  assign differs = sync2 ^ stable;
  assign accept  = differs && (cnt == CNT_LAST);

  // Any sample matching 'stable' restarts the window, so a glitch never half-counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (!differs || accept) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (accept) begin
        stable <= sync2;
      end
      pulse <= accept & sync2;
    end
  end

  assign level = stable;

  a_pulse_with_level : assert property (@(posedge clk) disable iff (reset) pulse |-> level);
  a_cnt_bounded      : assert property (@(posedge clk) disable iff (reset) cnt <= CNT_LAST);

endmodule

// File: rtl/seat_button_conditioner.sv
// Purpose: independent debounce of the passenger call and attendant cancel switches.
// Latency: DEBOUNCE_CYCLES+2 edges from raw level to button level, pulse coincident with the rise.
// Backpressure: none; priority between call and cancel is resolved downstream.
module seat_button_conditioner
  import seat_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  seat_button_conditioner_if.slave  btn
);

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_call (
    .clk   (clk),
    .reset (reset),
    .raw   (btn.call_raw),
    .level (btn.call_button),
    .pulse (btn.call_pulse)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_cancel (
    .clk   (clk),
    .reset (reset),
    .raw   (btn.cancel_raw),
    .level (btn.cancel_button),
    .pulse (btn.cancel_pulse)
  );

endmodule

// File: tb/tb_seat_button_conditioner.sv
// Purpose: vector table, corner-case sequences and random stimulus against a sliding-window model.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: not applicable.
module tb_seat_button_conditioner;
  import seat_ctrl_pkg::*;

  localparam int D    = DEBOUNCE_CYCLES_DEFAULT;
  localparam int HMAX = 16384;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seat_button_conditioner_if btn ();

  seat_button_conditioner #(
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (btn)
  );

  int checks = 0;
  int errors = 0;

  // Reference: a level is accepted once the synchronized input (raw delayed two
  // edges, zero before reset release) has differed from the output for D edges in a row.
  bit model_live = 1'b0;
  bit m_button [2];
  bit m_pulse  [2];
  bit raw_at   [2][HMAX];
  int t_rel = 0;

  function automatic bit obs_at(input int ch, input int t);
    return (t >= 2) ? raw_at[ch][t-2] : 1'b0;
  endfunction

  initial begin : ref_model
    bit raw_now [2];
    bit seen;
    bit all_diff;
    forever begin
      @(posedge clk);
      if (reset) begin
        t_rel = 0;
        for (int ch = 0; ch < 2; ch++) begin
          m_button[ch] = 1'b0;
          m_pulse[ch]  = 1'b0;
        end
        model_live = 1'b1;
      end else begin
        raw_now[0] = btn.call_raw;
        raw_now[1] = btn.cancel_raw;
        for (int ch = 0; ch < 2; ch++) begin
          seen     = obs_at(ch, t_rel);
          all_diff = 1'b1;
          for (int k = 0; k < D; k++) begin
            if (obs_at(ch, t_rel - k) == m_button[ch]) all_diff = 1'b0;
          end
          m_pulse[ch] = all_diff && seen;
          if (all_diff) m_button[ch] = seen;
          raw_at[ch][t_rel] = raw_now[ch];
        end
        t_rel++;
      end
    end
  end

  initial begin : model_checker
    logic [3:0] got;
    logic [3:0] exp;
    forever begin
      @(negedge clk);
      if (model_live) begin
        got = {btn.call_button, btn.cancel_button, btn.call_pulse, btn.cancel_pulse};
        exp = {m_button[0], m_button[1], m_pulse[0], m_pulse[1]};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL model_cmp t=%0t {cb,kb,cp,kp} got=%b exp=%b", $time, got, exp);
        end
      end
    end
  end

  task automatic cycle(input bit c, input bit k, input bit r);
    btn.call_raw   = c;
    btn.cancel_raw = k;
    reset          = r;
    @(negedge clk);
  endtask

  task automatic chk4(input string name, input int idx, input bit cb, input bit kb,
                      input bit cp, input bit kp);
    logic [3:0] got;
    got = {btn.call_button, btn.cancel_button, btn.call_pulse, btn.cancel_pulse};
    checks++;
    if (got !== {cb, kb, cp, kp}) begin
      errors++;
      $display("FAIL %s[%0d] {cb,kb,cp,kp} got=%b exp=%b", name, idx, got, {cb, kb, cp, kp});
    end
  endtask

  typedef struct {
    bit rst;
    bit call;
    bit cancel;
    bit e_cb;
    bit e_kb;
    bit e_cp;
    bit e_kp;
  } vec_t;

  vec_t tbl [20];

  initial begin : stimulus
    bit c, k, r;
    int seg_len, mode, rlen;

    btn.call_raw   = 1'b0;
    btn.cancel_raw = 1'b0;
    reset          = 1'b1;

    // rst call cancel | call_button cancel_button call_pulse cancel_pulse
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 1, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 1, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 1, 0, 0, 0, 0};
    tbl[8]  = '{0, 1, 1, 0, 0, 0, 0};
    tbl[9]  = '{0, 1, 1, 1, 1, 1, 1};
    tbl[10] = '{0, 1, 1, 1, 1, 0, 0};
    tbl[11] = '{0, 0, 1, 1, 1, 0, 0};
    tbl[12] = '{0, 0, 1, 1, 1, 0, 0};
    tbl[13] = '{0, 0, 1, 1, 1, 0, 0};
    tbl[14] = '{0, 0, 1, 1, 1, 0, 0};
    tbl[15] = '{0, 0, 1, 1, 1, 0, 0};
    tbl[16] = '{0, 0, 1, 0, 1, 0, 0};
    tbl[17] = '{0, 0, 1, 0, 1, 0, 0};
    tbl[18] = '{1, 0, 0, 0, 0, 0, 0};
    tbl[19] = '{1, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].call, tbl[i].cancel, tbl[i].rst);
      chk4("table", i, tbl[i].e_cb, tbl[i].e_kb, tbl[i].e_cp, tbl[i].e_kp);
    end

    // Bouncing press 1,0,1,0 then held: rise 5 rows after the final 0->1, single pulse.
    for (int i = 0; i < 15; i++) begin
      cycle((i < 4) ? ((i % 2) == 0) : 1'b1, 1'b0, 1'b0);
      chk4("bounce", i, (i >= 9), 1'b0, (i == 9), 1'b0);
    end

    // Three-cycle cancel glitch is one short of the window and must be ignored.
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, (i < 3), 1'b0);
      chk4("glitch", i, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Reset in the middle of a pending call, raw held high through and after reset.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      chk4("rst_idle", i, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      chk4("pre_abort", i, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 1'b1);
      chk4("abort_rst", i, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      chk4("after_abort", i, (i >= 5), 1'b0, (i == 5), 1'b0);
    end

    // Random segments: held levels, bouncy stretches, single toggles, occasional resets.
    c = 1'b1;
    k = 1'b0;
    for (int s = 0; s < 320; s++) begin
      seg_len = $urandom_range(1, 12);
      mode    = $urandom_range(0, 2);
      if (mode == 2) begin
        if ($urandom_range(0, 1) == 1) c = ~c;
        if ($urandom_range(0, 1) == 1) k = ~k;
      end
      for (int j = 0; j < seg_len; j++) begin
        if (mode == 1) begin
          c = 1'($urandom_range(0, 1));
          k = 1'($urandom_range(0, 1));
        end
        cycle(c, k, 1'b0);
      end
      if ($urandom_range(0, 39) == 0) begin
        rlen = $urandom_range(1, 3);
        for (int j = 0; j < rlen; j++) begin
          r = 1'b1;
          cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r);
        end
      end
    end

    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seat_button_conditioner.md
SEAT_BUTTON_CONDITIONER -- requirements
Module: seat_button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed to accept a level change; legal range 2..65535.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 call_raw  input  1  asynchronous, bouncy passenger call switch (1 = pressed).
REQ-005 cancel_raw  input  1  asynchronous, bouncy attendant cancel switch (1 = pressed).
REQ-006 call_button  output  1  debounced call level; drives flight_att_sys.call_button directly.
REQ-007 cancel_button  output  1  debounced cancel level; drives flight_att_sys.cancel_button directly.
REQ-008 call_pulse  output  1  one-cycle strobe on each debounced call press (0->1).
REQ-009 cancel_pulse  output  1  one-cycle strobe on each debounced cancel press (0->1).

Function
REQ-010 Each raw input SHALL pass through a private 2-flop synchronizer (sync1, sync2) before any other logic.
REQ-011 Each channel SHALL hold a registered stable level and a counter of width clog2(DEBOUNCE_CYCLES).
REQ-012 If sync2 == stable, the counter SHALL clear to 0 on that edge.
REQ-013 If sync2 != stable and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-014 If sync2 != stable and counter == DEBOUNCE_CYCLES-1, stable SHALL take sync2 and the counter SHALL clear; no wrap-around past DEBOUNCE_CYCLES-1.
REQ-015 Latency: a raw level held constant from rising edge 1 SHALL appear on the debounced output after rising edge DEBOUNCE_CYCLES+2 (edge 6 at default).
REQ-016 Any raw glitch that returns to the stable value before acceptance SHALL clear the counter and SHALL leave the output unchanged.
REQ-017 call_button/cancel_button SHALL be registered copies of each channel's stable level; no combinational path from raw inputs.
REQ-018 *_pulse SHALL be 1 for exactly the one cycle in which stable changes 0->1; 1->0 changes SHALL produce no pulse.
REQ-019 Channels SHALL be fully independent; simultaneous call and cancel presses SHALL both propagate with identical latency. Priority resolution belongs to flight_att_sys.
REQ-020 A held press SHALL produce a single pulse regardless of hold duration.

Reset
REQ-021 While reset is 1 at a rising edge: sync1, sync2, stable, counters, all outputs SHALL become 0.
REQ-022 Reset asserted mid-count SHALL abort the pending change; after release, debounce restarts from stable=0, counter=0.
REQ-023 A raw input already high at reset release SHALL be accepted after the full REQ-015 latency and SHALL generate one pulse.

Structure
REQ-024 Shared package seat_ctrl_pkg SHALL hold DEBOUNCE_CYCLES_DEFAULT (4) and the counter-width function/constant, reused by flight_att_sys benches.
REQ-025 One sub-module debounce_channel (sync + counter + stable + edge pulse) SHALL be instantiated twice, for call and cancel.
REQ-026 Top level SHALL contain only the two instances and output wiring; no further state.

Verification (DEBOUNCE_CYCLES=4, clk period 10 ns)
REQ-027 Reset for 2 cycles, raw inputs 0 -> all four outputs 0 throughout and after release.
REQ-028 call_raw 0->1 held 100 ns -> call_button 1 after edge 6, call_pulse high exactly that one cycle, cancel outputs stay 0.
REQ-029 call_raw bounces 1,0,1,0 every 10 ns, then holds 1 -> no output change during bounce; call_button rises 6 edges after final 0->1.
REQ-030 call_raw and cancel_raw both 0->1 on the same edge -> call_button and cancel_button rise on the same cycle, both pulses coincide.
REQ-031 cancel_raw high 30 ns then low -> cancel_button never rises, cancel_pulse never asserts.
REQ-032 reset asserted 3 cycles into a call count, call_raw held 1 -> outputs 0 during reset; call_button rises 6 edges after release with one call_pulse.
